lockstep_comparator: RTL

Parametrised run-time lockstep checker that compares output streams from a reference copy and a mutated or under-test copy of a design. It supports NCH channels of WIDTH bits, a fixed pipeline skew between the two copies, and per-channel masking. It captures the first divergence, counts all divergences and can optionally halt on the first one. It sits beside two top-level instances in simulation and FPGA self-check builds, and generalises the purely combinational equality miter.

---
 rtl/lockstep_pkg.sv | 18 +
 rtl/lockstep_delay.sv | 49 ++++
 rtl/lockstep_comparator.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lockstep_pkg.sv
// Shared types and helpers for the lockstep comparator: FSM states, error kinds
// and the width of the channel index.
package lockstep_pkg;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    COMPARE = 2'd1,
    HALTED  = 2'd2
  } state_e;

  localparam logic KIND_DATA  = 1'b0;
  localparam logic KIND_VALID = 1'b1;

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/lockstep_delay.sv
// Fixed-depth {valid, data} shift register that skews the ref stream; depth 0
// is a plain wire.
module lockstep_delay #(
  parameter int WIDTH_TOTAL = 16,
  parameter int DEPTH       = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [WIDTH_TOTAL-1:0] data_i,
  output logic                   valid_o,
  output logic [WIDTH_TOTAL-1:0] data_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk_i ^ rst_i;
    assign valid_o    = valid_i;
    assign data_o     = data_i;
  end else begin : g_pipe
    logic [DEPTH-1:0]                  vld_pipe_q, vld_pipe_d;
    logic [DEPTH-1:0][WIDTH_TOTAL-1:0] dat_pipe_q, dat_pipe_d;

    always_comb begin
      vld_pipe_d    = vld_pipe_q;
      dat_pipe_d    = dat_pipe_q;
      vld_pipe_d[0] = valid_i;
      dat_pipe_d[0] = data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        dat_pipe_d[i] = dat_pipe_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_pipe_q <= '0;
        dat_pipe_q <= '0;
      end else begin
        vld_pipe_q <= vld_pipe_d;
        dat_pipe_q <= dat_pipe_d;
      end
    end

    assign valid_o = vld_pipe_q[DEPTH-1];
    assign data_o  = dat_pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/lockstep_comparator.sv
// Run-time lockstep checker: aligns a skewed ref stream to the uut stream,
// flags divergences, captures the first one and counts all of them.
module lockstep_comparator
  import lockstep_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int NCH           = 1,
  parameter int SKEW          = 0,
  parameter int CNT_W         = 16,
  parameter int STOP_ON_FIRST = 1,
  localparam int CH_W         = ch_w(NCH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [NCH-1:0]       mask_i,
  input  logic                 ref_valid_i,
  input  logic [NCH*WIDTH-1:0] ref_data_i,
  input  logic                 uut_valid_i,
  input  logic [NCH*WIDTH-1:0] uut_data_i,
  output logic                 mismatch_o,
  output logic                 err_sticky_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic                 first_kind_o,
  output logic [CH_W-1:0]      first_ch_o,
  output logic [WIDTH-1:0]     first_ref_o,
  output logic [WIDTH-1:0]     first_uut_o,
  output logic [CNT_W-1:0]     first_cycle_o,
  output logic                 halted_o,
  output logic                 armed_o
);

  localparam logic [3:0] WARM_LAST = (SKEW > 0) ? 4'(SKEW - 1) : 4'd0;

  logic                 dly_valid;
  logic [NCH*WIDTH-1:0] dly_data;

  // Clearing the line on re-arm keeps stale pre-clear samples out of the compare.
  lockstep_delay #(.WIDTH_TOTAL(NCH*WIDTH), .DEPTH(SKEW)) u_dly (
    .clk_i   (clk_i),
    .rst_i   (rst_i | clear_i),
    .valid_i (ref_valid_i),
    .data_i  (ref_data_i),
    .valid_o (dly_valid),
    .data_o  (dly_data)
  );

  logic [NCH-1:0] ch_diff;
  for (genvar k = 0; k < NCH; k++) begin : g_diff
    assign ch_diff[k] = ~mask_i[k] &
                        (dly_data[k*WIDTH +: WIDTH] != uut_data_i[k*WIDTH +: WIDTH]);
  end

  state_e           state_q, state_d;
  logic [3:0]       warm_q, warm_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, cnt_q, cnt_d, fcyc_q, fcyc_d;
  logic             mism_q, mism_d, sticky_q, sticky_d, kind_q, kind_d;
  logic [CH_W-1:0]  fch_q, fch_d, fail_ch, cap_ch;
  logic [WIDTH-1:0] fref_q, fref_d, fuut_q, fuut_d;
  logic             valid_err, data_err;

  always_comb begin
    fail_ch = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (ch_diff[k]) fail_ch = CH_W'(k);
    end
  end

  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    mism_d    = 1'b0;
    sticky_d  = sticky_q;
    kind_d    = kind_q;
    fch_d     = fch_q;
    fref_d    = fref_q;
    fuut_d    = fuut_q;
    fcyc_d    = fcyc_q;
    valid_err = dly_valid != uut_valid_i;
    data_err  = dly_valid & uut_valid_i & (|ch_diff);
    cap_ch    = valid_err ? '0 : fail_ch;
    case (state_q)
      WARMUP: begin
        if (en_i) begin
          if (warm_q == WARM_LAST) state_d = COMPARE;
          else                     warm_d  = warm_q + 4'd1;
        end
      end
      COMPARE: begin
        if (en_i) begin
          cyc_d = cyc_q + 1'b1;
          if (valid_err || data_err) begin
            mism_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (!sticky_q) begin
              sticky_d = 1'b1;
              kind_d   = valid_err ? KIND_VALID : KIND_DATA;
              fch_d    = cap_ch;
              fref_d   = dly_data[cap_ch*WIDTH +: WIDTH];
              fuut_d   = uut_data_i[cap_ch*WIDTH +: WIDTH];
              fcyc_d   = cyc_q;
            end
            if (STOP_ON_FIRST != 0) state_d = HALTED;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q  <= WARMUP;
      warm_q   <= '0;
      cyc_q    <= '0;
      cnt_q    <= '0;
      mism_q   <= 1'b0;
      sticky_q <= 1'b0;
      kind_q   <= 1'b0;
      fch_q    <= '0;
      fref_q   <= '0;
      fuut_q   <= '0;
      fcyc_q   <= '0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      mism_q   <= mism_d;
      sticky_q <= sticky_d;
      kind_q   <= kind_d;
      fch_q    <= fch_d;
      fref_q   <= fref_d;
      fuut_q   <= fuut_d;
      fcyc_q   <= fcyc_d;
    end
  end

  assign mismatch_o    = mism_q;
  assign err_sticky_o  = sticky_q;
  assign err_count_o   = cnt_q;
  assign first_kind_o  = kind_q;
  assign first_ch_o    = fch_q;
  assign first_ref_o   = fref_q;
  assign first_uut_o   = fuut_q;
  assign first_cycle_o = fcyc_q;
  assign halted_o      = (state_q == HALTED);
  assign armed_o       = (state_q == COMPARE);

endmodule
